// File: rtl/car_motion_controller_pkg.sv
// Shared constants for the car motion controller, the sprite display and the
// collision logic: lane reset positions, lane frame periods, lane Y rows and
// the default lane direction pattern.
package car_motion_controller_pkg;

    // Lane index 0..4 corresponds to lanes 1..5.
    localparam logic [4:0][9:0] C_CAR_RESET_X = {10'd512, 10'd384, 10'd256, 10'd128, 10'd0};

    // Number of frames between moves for each lane (lane 1 in element 0).
    localparam logic [4:0][1:0] C_LANE_PERIOD = {2'd2, 2'd3, 2'd1, 2'd2, 2'd1};

    // Lane Y rows used by the sprite display and the collision logic.
    localparam logic [9:0] C_LINE_1_Y = 10'd64;
    localparam logic [9:0] C_LINE_2_Y = 10'd128;
    localparam logic [9:0] C_LINE_3_Y = 10'd192;
    localparam logic [9:0] C_LINE_4_Y = 10'd256;
    localparam logic [9:0] C_LINE_5_Y = 10'd320;
    localparam logic [9:0] C_LINE_6_Y = 10'd384;

    // 1 = moving right. Lane 5 reuses bit 0.
    localparam logic [3:0] C_LANE_DIR = 4'b0101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Direction flag for a lane index 0..4; lane 5 shares the lane 1 bit.
    function automatic logic lane_dir_bit(input logic [3:0] dir, input logic [2:0] lane);
        if (lane == 3'd4) begin
            return dir[0];
        end
        return dir[lane[1:0]];
    endfunction

endpackage

// File: rtl/car_motion_controller_if.sv
// Frame handshake and car position bus between the frame timing logic,
// the motion controller and the sprite display.
interface car_motion_controller_if;
    logic       i_Frame_Tick;
    logic [1:0] i_Level;
    logic       i_Pause;
    logic [9:0] o_Car_1X_Position;
    logic [9:0] o_Car_2X_Position;
    logic [9:0] o_Car_3X_Position;
    logic [9:0] o_Car_4X_Position;
    logic [9:0] o_Car_5X_Position;
    logic [3:0] o_Reverse;
    logic       o_Busy;
    logic       o_Update_Done;

    modport master (
        output i_Frame_Tick, i_Level, i_Pause,
        input  o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position,
               o_Car_4X_Position, o_Car_5X_Position, o_Reverse, o_Busy, o_Update_Done
    );

    modport slave (
        input  i_Frame_Tick, i_Level, i_Pause,
        output o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position,
               o_Car_4X_Position, o_Car_5X_Position, o_Reverse, o_Busy, o_Update_Done
    );
endinterface

// File: rtl/car_motion_controller_lane_step.sv
// Combinational wrap-around adder: moves one car X by step pixels in the
// lane direction, wrapping inside 0..H_VISIBLE_AREA-1.
module car_lane_step #(
    parameter int H_VISIBLE_AREA = 640
) (
    input  logic [9:0] x,
    input  logic [2:0] step,
    input  logic       dir,
    output logic [9:0] new_x
);
    localparam logic [10:0] MODULUS = 11'(H_VISIBLE_AREA);

    logic [10:0] x_w;
    logic [10:0] step_w;
    logic [10:0] sum;

    assign x_w    = {1'b0, x};
    assign step_w = {8'd0, step};
    assign sum    = x_w + step_w;

    // Right wraps past the right edge; left borrows a full line width when it would go negative.
    always_comb begin
        new_x = x;
        if (dir) begin
            if (sum >= MODULUS) begin
                new_x = 10'(sum - MODULUS);
            end else begin
                new_x = 10'(sum);
            end
        end else begin
            if (x_w < step_w) begin
                new_x = 10'(x_w + MODULUS - step_w);
            end else begin
                new_x = 10'(x_w - step_w);
            end
        end
    end
endmodule

// File: rtl/car_motion_controller.sv
// Frame-synchronous car X position generator. Each accepted frame tick walks
// the five lanes one per cycle through a single shared wrap adder; outputs
// therefore only change during vertical blanking.
module car_motion_controller
    import car_motion_controller_pkg::*;
#(
    parameter int         H_VISIBLE_AREA = 640,
    parameter int         NUM_LANES      = 5,
    parameter logic [3:0] LANE_DIR       = C_LANE_DIR
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    car_motion_controller_if.slave  bus
);
    state_t     state_q;
    state_t     state_n;
    logic [2:0] idx_q;
    logic [2:0] step_q;
    logic       pause_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] reverse_q;
    logic [9:0] x_q   [NUM_LANES];
    logic [1:0] cnt_q [NUM_LANES];

    logic [2:0] lane_sel;
    logic       lane_dir;
    logic [1:0] lane_last;
    logic [9:0] lane_new_x;

    // Next-state logic: one lane per UPDATE cycle, then a single DONE cycle.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.i_Frame_Tick) state_n = UPDATE;
            UPDATE:  if (idx_q == 3'd4) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select the lane being processed and its direction / period terminal count.
    always_comb begin
        lane_sel = idx_q;
        if (idx_q > 3'd4) begin
            lane_sel = 3'd0;
        end
        lane_dir  = lane_dir_bit(LANE_DIR, lane_sel);
        lane_last = C_LANE_PERIOD[lane_sel] - 2'd1;
    end

    car_lane_step #(
        .H_VISIBLE_AREA (H_VISIBLE_AREA)
    ) u_lane_step (
        .x     (x_q[lane_sel]),
        .step  (step_q),
        .dir   (lane_dir),
        .new_x (lane_new_x)
    );

    // State register, frame parameters latched on the accepted tick, and status flags.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            step_q    <= 3'd1;
            pause_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            reverse_q <= LANE_DIR;
        end else begin
            state_q   <= state_n;
            busy_q    <= (state_q != IDLE);
            done_q    <= (state_q == DONE);
            reverse_q <= LANE_DIR;
            if (state_q == IDLE && bus.i_Frame_Tick) begin
                step_q  <= {1'b0, bus.i_Level} + 3'd1;
                pause_q <= bus.i_Pause;
                idx_q   <= 3'd0;
            end else if (state_q == UPDATE) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Per-lane position and frame counter; a lane moves only when its counter hits the period.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                x_q[i]   <= C_CAR_RESET_X[i];
                cnt_q[i] <= 2'd0;
            end
        end else if (state_q == UPDATE && !pause_q) begin
            if (cnt_q[lane_sel] == lane_last) begin
                x_q[lane_sel]   <= lane_new_x;
                cnt_q[lane_sel] <= 2'd0;
            end else begin
                cnt_q[lane_sel] <= cnt_q[lane_sel] + 2'd1;
            end
        end
    end

    assign bus.o_Car_1X_Position = x_q[0];
    assign bus.o_Car_2X_Position = x_q[1];
    assign bus.o_Car_3X_Position = x_q[2];
    assign bus.o_Car_4X_Position = x_q[3];
    assign bus.o_Car_5X_Position = x_q[4];
    assign bus.o_Reverse         = reverse_q;
    assign bus.o_Busy            = busy_q;
    assign bus.o_Update_Done     = done_q;
endmodule

// File: tb/tb_car_motion_controller.sv
// Bench for car_motion_controller: directed frame sequences against a
// behavioural lane model, plus hand-computed position checkpoints.
module tb_car_motion_controller;
    logic clk;
    logic rst_n;

    car_motion_controller_if bus();

    car_motion_controller dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: positions, frames elapsed since last move, frame phase.
    int mx   [5];
    int mcnt [5];
    int mperiod [5] = '{1, 2, 1, 3, 2};
    int msign   [5] = '{1, -1, 1, -1, 1};
    int phase;
    int m_step;
    bit m_pause;

    task automatic model_reset();
        mx   = '{0, 128, 256, 384, 512};
        mcnt = '{0, 0, 0, 0, 0};
        phase = -1;
    endtask

    task automatic model_commit(input int k);
        int nx;
        if (!m_pause) begin
            mcnt[k] = mcnt[k] + 1;
            if (mcnt[k] == mperiod[k]) begin
                nx = (mx[k] + msign[k] * m_step) % 640;
                if (nx < 0) nx = nx + 640;
                mx[k] = nx;
                mcnt[k] = 0;
            end
        end
    endtask

    task automatic model_edge(input bit tick, input int lvl, input bit pause);
        bit idle;
        idle = (phase < 0) || (phase == 6);
        if (phase >= 0) begin
            phase = phase + 1;
            if (phase >= 1 && phase <= 5) model_commit(phase - 1);
            if (phase == 7) phase = -1;
        end
        if (idle && tick) begin
            phase   = 0;
            m_step  = lvl + 1;
            m_pause = pause;
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("car1_x", int'(bus.o_Car_1X_Position), mx[0]);
        check_val("car2_x", int'(bus.o_Car_2X_Position), mx[1]);
        check_val("car3_x", int'(bus.o_Car_3X_Position), mx[2]);
        check_val("car4_x", int'(bus.o_Car_4X_Position), mx[3]);
        check_val("car5_x", int'(bus.o_Car_5X_Position), mx[4]);
        check_val("reverse", int'(bus.o_Reverse), 5);
        check_val("busy", int'(bus.o_Busy), (phase >= 1 && phase <= 6) ? 1 : 0);
        check_val("update_done", int'(bus.o_Update_Done), (phase == 6) ? 1 : 0);
    endtask

    task automatic cycle(input bit tick, input int lvl, input bit pause);
        bus.i_Frame_Tick = tick;
        bus.i_Level      = 2'(lvl);
        bus.i_Pause      = pause;
        @(posedge clk);
        model_edge(tick, lvl, pause);
        @(negedge clk);
        check_all();
    endtask

    task automatic frame(input int lvl, input bit pause);
        cycle(1'b1, lvl, pause);
        repeat (6) cycle(1'b0, lvl, pause);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_Frame_Tick = 1'b0;
        bus.i_Level = 2'd0;
        bus.i_Pause = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check_val("rst_car1", int'(bus.o_Car_1X_Position), 0);
        check_val("rst_car5", int'(bus.o_Car_5X_Position), 512);
        check_val("rst_busy", int'(bus.o_Busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First tick after reset, level 0.
        cycle(1'b1, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        check_val("t1_car1_T1", int'(bus.o_Car_1X_Position), 1);
        check_val("t1_car2_T1", int'(bus.o_Car_2X_Position), 128);
        repeat (5) cycle(1'b0, 0, 1'b0);
        check_val("t1_done_T6", int'(bus.o_Update_Done), 1);
        check_val("t1_busy_T6", int'(bus.o_Busy), 1);
        cycle(1'b0, 0, 1'b0);
        check_val("t1_done_T7", int'(bus.o_Update_Done), 0);
        check_val("t1_busy_T7", int'(bus.o_Busy), 0);

        // Ticks 2..639 at level 0.
        for (int t = 2; t <= 639; t++) begin
            frame(0, 1'b0);
            if (t == 2) check_val("lane4_tick2", int'(bus.o_Car_4X_Position), 384);
            if (t == 3) check_val("lane4_tick3", int'(bus.o_Car_4X_Position), 383);
            if (t == 6) check_val("lane4_tick6", int'(bus.o_Car_4X_Position), 382);
        end
        check_val("car1_639", int'(bus.o_Car_1X_Position), 639);
        check_val("car2_639", int'(bus.o_Car_2X_Position), 449);
        check_val("car3_639", int'(bus.o_Car_3X_Position), 255);
        check_val("car4_639", int'(bus.o_Car_4X_Position), 171);
        check_val("car5_639", int'(bus.o_Car_5X_Position), 191);
        frame(0, 1'b0);
        check_val("car1_wrap_right", int'(bus.o_Car_1X_Position), 0);
        frame(0, 1'b0);
        frame(0, 1'b0);
        for (int t = 0; t < 95; t++) frame(3, 1'b0);
        check_val("car3_638", int'(bus.o_Car_3X_Position), 638);
        frame(3, 1'b0);
        check_val("car3_wrap_step4", int'(bus.o_Car_3X_Position), 2);
        check_val("car1_386", int'(bus.o_Car_1X_Position), 386);

        // Paused frame with a second tick attempted mid-update.
        cycle(1'b1, 2, 1'b1);
        cycle(1'b0, 2, 1'b1);
        cycle(1'b0, 2, 1'b1);
        cycle(1'b1, 0, 1'b0);
        check_val("pause_busy_T3", int'(bus.o_Busy), 1);
        repeat (3) cycle(1'b0, 0, 1'b0);
        check_val("pause_done_T6", int'(bus.o_Update_Done), 1);
        cycle(1'b0, 0, 1'b0);
        check_val("pause_car1", int'(bus.o_Car_1X_Position), 386);
        check_val("pause_car3", int'(bus.o_Car_3X_Position), 2);
        check_val("pause_busy_T7", int'(bus.o_Busy), 0);

        // Reset asserted mid-update.
        cycle(1'b1, 0, 1'b0);
        repeat (3) cycle(1'b0, 0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check_val("mid_rst_car1", int'(bus.o_Car_1X_Position), 0);
        check_val("mid_rst_car2", int'(bus.o_Car_2X_Position), 128);
        check_val("mid_rst_car4", int'(bus.o_Car_4X_Position), 384);
        check_val("mid_rst_busy", int'(bus.o_Busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        check_val("post_rst_car1", int'(bus.o_Car_1X_Position), 1);
        repeat (5) cycle(1'b0, 0, 1'b0);
        check_val("post_rst_done", int'(bus.o_Update_Done), 1);
        cycle(1'b0, 0, 1'b0);

        // Lane 2 left wrap: 128 -> 127 -> ... -> 1 -> 639.
        frame(0, 1'b0);
        check_val("car2_127", int'(bus.o_Car_2X_Position), 127);
        for (int t = 0; t < 126; t++) frame(1, 1'b0);
        check_val("car2_1", int'(bus.o_Car_2X_Position), 1);
        frame(1, 1'b0);
        frame(1, 1'b0);
        check_val("car2_wrap_left", int'(bus.o_Car_2X_Position), 639);

        // Lane 4 from 0 with step 4.
        pulse_reset();
        for (int t = 0; t < 288; t++) frame(3, 1'b0);
        check_val("car4_0", int'(bus.o_Car_4X_Position), 0);
        repeat (3) frame(3, 1'b0);
        check_val("car4_wrap_left", int'(bus.o_Car_4X_Position), 636);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/car_motion_controller.md
# car_motion_controller

Frame-synchronous generator of the five car X positions and lane direction flags consumed by the sprite display stage. Each accepted frame tick starts a serial update, one lane per cycle, through one shared wrap-around adder. Each car advances by a level-dependent step at its lane's frame rate. All outputs change only inside vertical blanking, so the display never shows a torn car.

## Interface
- `H_VISIBLE_AREA`, 640: horizontal wrap modulus in pixels.
- `NUM_LANES`, 5: number of car lanes; fixed at 5.
- `LANE_DIR`, 4'b0101: per-bit lane direction; 1 = moving right (increasing X), 0 = moving left.
- `i_Clk`  in  1  system clock. One clock domain.
- `i_Rst_L`  in  1  asynchronous, active-low reset.
- `i_Frame_Tick`  in  1  one-cycle pulse at the start of vertical blanking.
- `i_Level`  in  2  speed level; step = i_Level + 1 pixels (1..4).
- `i_Pause`  in  1  freezes motion when high.
- `o_Car_1X_Position` … `o_Car_5X_Position`  out  10 each  car left-edge X, range 0..639.
- `o_Reverse`  out  4  lane direction flags. Constant `LANE_DIR`; lane 5 shares bit 0 with lane 1.
- `o_Busy`  out  1  high while the lane update is in progress.
- `o_Update_Done`  out  1  one-cycle pulse after lane 5 is written.

## Operation
- Reset values:
  - Lanes 1..5 X = 0, 128, 256, 384, 512.
  - Frame counters = 0; FSM = IDLE; `o_Busy` = 0; `o_Update_Done` = 0.
  - `o_Reverse` = `LANE_DIR`.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE → UPDATE on `i_Frame_Tick`. On that same edge, latch `i_Level` and `i_Pause`, and set the lane index to 0.
  - UPDATE processes lane `idx` in one cycle, then increments `idx`. After idx = 4 it goes to DONE.
  - DONE pulses `o_Update_Done`, then returns to IDLE.
- Per-lane frame period, lanes 1..5 = 1, 2, 1, 3, 2 frames. Each lane has a 2-bit counter.
  - counter == period-1: move the car and clear the counter.
  - otherwise: increment the counter and leave X unchanged.
- Moving right: sum = X + step (11-bit). If sum ≥ 640, X = sum − 640; else X = sum.
- Moving left: if X < step, X = X + 640 − step; else X = X − step.
- Result is always 0..639. Widths are 11-bit internally and truncated to 10 bits on write.
- Lane direction bit: lane k uses `LANE_DIR[k-1]` for k = 1..4. Lane 5 uses `LANE_DIR[0]`.
- Latched pause = 1: no X change and no counter change. The FSM still walks UPDATE/DONE and `o_Update_Done` still pulses.
- `i_Frame_Tick` while not in IDLE is ignored (no queueing).
- `i_Level` and `i_Pause` changes mid-update have no effect until the next accepted tick.
- Reset asserted mid-update: all state returns immediately to reset values. A partial frame is discarded.

## Timing
- Tick sampled at edge T:
  - Lane 1 is written at edge T+1, lane k at edge T+k.
  - `o_Update_Done` is high for the cycle after edge T+6.
  - `o_Busy` is high from edge T+1 through edge T+6.
- Total latency is 6 cycles, far inside blanking (≥ 45 lines).
- Outputs are registered, with no combinational path from inputs to outputs.
- Minimum spacing between accepted ticks is 7 cycles.

## Structure
- Shared constants file, shared with the sprite display and the collision logic:
  - `C_CAR_RESET_X[1..5]` (lane reset positions).
  - `C_LANE_PERIOD[1..5]` (lane frame periods).
  - `C_LINE_1_Y` … `C_LINE_6_Y` (lane Y rows).
  - Default `LANE_DIR`.
- Sub-module `car_lane_step`: combinational wrap adder. Inputs are X, step and direction; output is the new X. Instantiated once and time-shared by the FSM.

## Test plan
- Reset release, level 0, no pause, one tick → lane 1 X 0→1 at T+1. Lane 2 (left, period 2) unchanged, counter goes to 1. `o_Update_Done` at T+6.
- Lane 1 at X = 639 (right), level 0, one tick → X = 0. Lane 3 at X = 638 with level 3 (step 4) → X = 2.
- Lane 2 at X = 1 (left), level 1 (step 2), period satisfied → X = 639. Lane 4 at X = 0, step 4 → X = 636.
- Pause = 1 at tick → all X and counters unchanged. `o_Update_Done` still pulses at T+6. A second tick at T+3 is ignored (`o_Busy` = 1).
- Reset asserted at T+3 (lanes 1–2 already written) → all X return to 0, 128, 256, 384, 512 immediately and `o_Busy` = 0. The next tick behaves as the first after reset.
- Lane 4 over 6 ticks, level 0 → moves only on ticks 3 and 6: 384→383→382.
